// File: rtl/avmm_lvds_bridge_tx_arbiter.sv
// Round-robin packet arbiter for the bridge TX channel.
// Prepends a header word to each packet and reserves far-end rx FIFO space with word credits.
module avmm_lvds_bridge_tx_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned CREDITS = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NREQ-1:0]              req_i,
  input  logic [NREQ*16-1:0]           len_i,
  input  logic [NREQ-1:0]              dvalid_i,
  input  logic [NREQ*32-1:0]           data_i,
  output logic [NREQ-1:0]              pop_o,
  output logic [NREQ-1:0]              grant_o,
  output logic [NREQ-1:0]              done_o,
  input  logic                         credit_ret_i,
  output logic [$clog2(CREDITS):0]     credits_o,
  output logic [31:0]                  wr_data_o,
  output logic                         wr_req_o,
  output logic                         err_o
);

  localparam int unsigned CW = $clog2(CREDITS) + 1;
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_IDLE, S_PAYLOAD} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [15:0]       rem_q, rem_d;
  logic [CW-1:0]     credits_q, credits_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              wr_req_q, wr_req_d;
  logic              err_q, err_d;

  logic              cand_found;
  logic [IW-1:0]     cand_idx;
  logic [15:0]       cand_len;
  logic              skip_err;
  logic              grant_now;
  logic              credit_ovf;
  logic [CW-1:0]     reserve;
  logic [31:0]       data_sel;
  int unsigned       idx;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] k);
    return (32'(k) == NREQ - 1) ? '0 : k + IW'(1);
  endfunction

  // First pending requester from rr_ptr onward; over-length requests are skipped and flagged
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_len   = '0;
    skip_err   = 1'b0;
    idx        = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_ptr_q) + i) % NREQ;
      if (!cand_found && req_i[idx]) begin
        if (32'(len_i[idx*16 +: 16]) > MAX_LEN) begin
          skip_err = 1'b1;
        end else begin
          cand_found = 1'b1;
          cand_idx   = IW'(idx);
          cand_len   = len_i[idx*16 +: 16];
        end
      end
    end
  end

  assign grant_now  = (state_q == S_IDLE) && cand_found &&
                      (32'(credits_q) >= 32'(cand_len) + 32'd1);
  assign reserve    = grant_now ? CW'(32'(cand_len) + 32'd1) : '0;
  assign credit_ovf = credit_ret_i && (credits_q == CW'(CREDITS)) && !grant_now;
  assign data_sel   = data_i[32'(idx_q)*32 +: 32];

  always_comb begin
    pop_o = '0;
    if (state_q == S_PAYLOAD) pop_o[idx_q] = dvalid_i[idx_q];
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    grant_d   = grant_q;
    done_d    = '0;
    wr_req_d  = 1'b0;
    wr_data_d = wr_data_q;
    err_d     = credit_ovf;
    credits_d = credits_q - reserve + CW'(credit_ret_i && !credit_ovf);
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        err_d   = credit_ovf | skip_err;
        if (grant_now) begin
          grant_d   = NREQ'(1) << cand_idx;
          wr_req_d  = 1'b1;
          wr_data_d = {8'hA5, 8'(cand_idx), cand_len};
          idx_d     = cand_idx;
          if (cand_len == 16'd0) begin
            done_d   = NREQ'(1) << cand_idx;
            rr_ptr_d = next_ptr(cand_idx);
          end else begin
            rem_d   = cand_len;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (dvalid_i[idx_q]) begin
          wr_req_d  = 1'b1;
          wr_data_d = data_sel;
          rem_d     = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            done_d   = grant_q;
            rr_ptr_d = next_ptr(idx_q);
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      credits_q <= CW'(CREDITS);
      grant_q   <= '0;
      done_q    <= '0;
      wr_data_q <= '0;
      wr_req_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      credits_q <= credits_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      wr_data_q <= wr_data_d;
      wr_req_q  <= wr_req_d;
      err_q     <= err_d;
    end
  end

  assign grant_o   = grant_q;
  assign done_o    = done_q;
  assign credits_o = credits_q;
  assign wr_data_o = wr_data_q;
  assign wr_req_o  = wr_req_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_avmm_lvds_bridge_tx_arbiter.sv
// Directed bench for avmm_lvds_bridge_tx_arbiter: write-stream scoreboard plus per-cycle checks.
module tb_avmm_lvds_bridge_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, dv, pop, grant, done;
  logic [31:0] len;
  logic [63:0] data;
  logic        ret;
  logic [10:0] credits;
  logic [31:0] wr_data;
  logic        wr_req, err;

  logic [1:0]  req8, pop8, grant8, done8;
  logic [31:0] len8;
  logic        ret8;
  logic [3:0]  credits8;
  logic [31:0] wr_data8;
  logic        wr_req8, err8;

  logic [15:0] src_idx [2];
  logic [15:0] exp_idx [2];
  logic [31:0] exp_q [$];
  logic [31:0] exp_w;
  logic [4:0]  pat;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  avmm_lvds_bridge_tx_arbiter #(.NREQ(2), .MAX_LEN(16), .CREDITS(1024)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .len_i(len), .dvalid_i(dv), .data_i(data),
    .pop_o(pop), .grant_o(grant), .done_o(done), .credit_ret_i(ret), .credits_o(credits),
    .wr_data_o(wr_data), .wr_req_o(wr_req), .err_o(err));

  avmm_lvds_bridge_tx_arbiter #(.NREQ(2), .MAX_LEN(16), .CREDITS(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .req_i(req8), .len_i(len8), .dvalid_i(2'b11), .data_i(64'h0),
    .pop_o(pop8), .grant_o(grant8), .done_o(done8), .credit_ret_i(ret8), .credits_o(credits8),
    .wr_data_o(wr_data8), .wr_req_o(wr_req8), .err_o(err8));

  // Show-ahead source per requester: word = {DA, k, running index}
  always @(posedge clk) begin
    if (rst) begin
      src_idx[0] <= '0;
      src_idx[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) if (pop[k]) src_idx[k] <= src_idx[k] + 16'd1;
    end
  end
  assign data = {8'hDA, 8'd1, src_idx[1], 8'hDA, 8'd0, src_idx[0]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic push_pkt(input int k, input int n);
    exp_q.push_back({8'hA5, 8'(k), 16'(n)});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'hDA, 8'(k), exp_idx[k]});
      exp_idx[k] = exp_idx[k] + 16'd1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every tx FIFO write must match the next expected word
  always @(negedge clk) begin
    if (wr_req) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_unexpected got=%08h exp=none", wr_data);
      end
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("sb_word", wr_data, exp_w);
      end
    end
  end

  initial begin
    rst = 1'b1; req = 2'b11; len = {16'd1, 16'd1}; dv = 2'b11; ret = 1'b0;
    req8 = '0; len8 = '0; ret8 = 1'b0;
    exp_idx[0] = '0; exp_idx[1] = '0;

    // Reset held 3 clocks with requests pending
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_wr_req", 32'(wr_req), 0);
      check("rst_grant", 32'(grant), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_pop", 32'(pop), 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_credits", 32'(credits), 1024);
    end

    // Single packet req0 len=3
    rst = 1'b0; req = 2'b01; len = {16'd0, 16'd3}; dv = 2'b01;
    push_pkt(0, 3);
    step();
    check("p1_hdr", wr_data, 32'hA500_0003);
    check("p1_grant", 32'(grant), 1);
    check("p1_credits", 32'(credits), 1020);
    check("p1_pop", 32'(pop), 1);
    req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      check("p1_wr_req", 32'(wr_req), 1);
      check("p1_done", 32'(done), (i == 2) ? 1 : 0);
    end
    check("p1_last_grant", 32'(grant), 1);
    step();
    check("p1_idle_grant", 32'(grant), 0);
    check("p1_idle_wr", 32'(wr_req), 0);

    // len=0 on req1: header only, done in the header cycle
    req = 2'b10; len = {16'd0, 16'd0};
    push_pkt(1, 0);
    step();
    check("l0_done", 32'(done), 2);
    check("l0_grant", 32'(grant), 2);
    check("l0_credits", 32'(credits), 1019);
    req = 2'b00;
    step();
    check("l0_grant_drop", 32'(grant), 0);
    check("l0_done_drop", 32'(done), 0);

    // Both requesting len=2: alternating, back-to-back
    req = 2'b11; len = {16'd2, 16'd2}; dv = 2'b11;
    for (int p = 0; p < 4; p++) push_pkt(p % 2, 2);
    for (int c = 1; c <= 12; c++) begin
      step();
      check("rr_wr_req", 32'(wr_req), 1);
      check("rr_grant", 32'(grant), (((c - 1) / 3) % 2 == 0) ? 1 : 2);
      check("rr_done", 32'(done), (c % 3 == 0) ? 32'(grant) : 0);
      if (c == 9) req[0] = 1'b0;
      if (c == 12) req[1] = 1'b0;
    end
    step();
    check("rr_idle", 32'(wr_req), 0);
    check("rr_credits", 32'(credits), 1007);

    // Over-length req0 skipped with error, req1 served
    req = 2'b11; len = {16'd1, 16'd17};
    push_pkt(1, 1);
    step();
    check("bad_err", 32'(err), 1);
    check("bad_grant", 32'(grant), 2);
    req = 2'b00; len = '0;
    step();
    check("bad_done", 32'(done), 2);
    check("bad_err_clr", 32'(err), 0);
    step();
    check("bad_idle", 32'(grant), 0);
    check("bad_credits", 32'(credits), 1005);

    // Refill to full, then one extra return is an error
    ret = 1'b1;
    for (int i = 0; i < 19; i++) begin
      step();
      check("ret_err", 32'(err), 0);
    end
    check("ret_full", 32'(credits), 1024);
    step();
    check("ovf_err", 32'(err), 1);
    check("ovf_credits", 32'(credits), 1024);
    ret = 1'b0;
    step();
    check("ovf_err_clr", 32'(err), 0);

    // dvalid gaps propagate to write strobe gaps
    req = 2'b01; len = {16'd0, 16'd3};
    push_pkt(0, 3);
    step();
    check("gap_hdr", wr_data, 32'hA500_0003);
    req = 2'b00;
    pat = 5'b11010;
    for (int i = 0; i < 5; i++) begin
      dv = {1'b0, pat[i]};
      step();
      check("gap_wr_req", 32'(wr_req), 32'(pat[i]));
      check("gap_done", 32'(done), (i == 4) ? 1 : 0);
      if (i == 0) check("gap_hold", wr_data, 32'hA500_0003);
    end
    dv = 2'b11;
    step();
    check("gap_credits", 32'(credits), 1020);

    // Credit-limited instance: req0 waits for credits, req1 must not overtake it
    req8 = 2'b10; len8 = {16'd7, 16'd0};
    step();
    check("c8_hdr1", wr_data8, 32'hA501_0007);
    check("c8_credits0", 32'(credits8), 0);
    req8 = 2'b11; len8 = {16'd0, 16'd7};
    for (int i = 0; i < 7; i++) step();
    check("c8_done1", 32'(done8), 2);
    check("c8_grant1", 32'(grant8), 2);
    ret8 = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      step();
      check("c8_credits", 32'(credits8), 32'(r));
      check("c8_wait_wr", 32'(wr_req8), 0);
      check("c8_wait_grant", 32'(grant8), 0);
    end
    ret8 = 1'b0;
    step();
    check("c8_hdr2_wr", 32'(wr_req8), 1);
    check("c8_hdr2", wr_data8, 32'hA500_0007);
    check("c8_grant2", 32'(grant8), 1);
    check("c8_credits_res", 32'(credits8), 0);
    req8 = 2'b00;
    for (int i = 0; i < 7; i++) step();
    check("c8_done2", 32'(done8), 1);

    // Reset during payload abandons the packet
    req = 2'b01; len = {16'd0, 16'd5}; dv = 2'b01;
    exp_q.push_back(32'hA500_0005);
    exp_q.push_back({8'hDA, 8'd0, exp_idx[0]});
    exp_q.push_back({8'hDA, 8'd0, exp_idx[0] + 16'd1});
    step();
    check("mr_credits", 32'(credits), 1014);
    req = 2'b00;
    step();
    step();
    rst = 1'b1;
    step();
    check("mr_wr_req", 32'(wr_req), 0);
    check("mr_grant", 32'(grant), 0);
    check("mr_pop", 32'(pop), 0);
    check("mr_done", 32'(done), 0);
    check("mr_wr_data", wr_data, 0);
    check("mr_credits_rst", 32'(credits), 1024);
    rst = 1'b0; exp_idx[0] = '0; exp_idx[1] = '0;
    req = 2'b10; len = {16'd1, 16'd0}; dv = 2'b11;
    push_pkt(1, 1);
    step();
    check("mr_new_hdr", wr_data, 32'hA501_0001);
    check("mr_new_grant", 32'(grant), 2);
    req = 2'b00;
    step();
    check("mr_new_done", 32'(done), 2);
    step();
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
